// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the K-bit-per-cycle sequential multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    function automatic int steps(input int n, input int k);
        return n / k;
    endfunction

    // One spare bit so the counter can hold steps-1 for any legal N/K.
    function automatic int cnt_w(input int n, input int k);
        return $clog2(n / k) + 1;
    endfunction

endpackage

// File: rtl/seq_mult_rk_if.sv
// Operand/result valid-ready bundle between producer, multiplier and consumer.
interface seq_mult_rk_if #(
    parameter int N = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           is_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] p;

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, p
    );

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, p
    );
endinterface

// File: rtl/mult_step.sv
// One shift-add step: folds mcand * mplier[K-1:0] into the upper half, then shifts
// the {acc_hi, mplier} pair right by K.
module mult_step #(
    parameter int N = 8,
    parameter int K = 1
) (
    input  logic [N-1:0] i_hi,
    input  logic [N-1:0] i_mplier,
    input  logic [N-1:0] i_mcand,
    output logic [N-1:0] o_hi,
    output logic [N-1:0] o_lo
);
    // N+K bits cannot overflow: (2^N-1) + (2^N-1)(2^K-1) = (2^N-1)*2^K.
    logic [N+K-1:0] w_sum;

    assign w_sum = {{K{1'b0}}, i_hi}
                 + ({{K{1'b0}}, i_mcand} * {{N{1'b0}}, i_mplier[K-1:0]});

    assign o_hi = w_sum[N+K-1:K];

    generate
        if (K == N) begin : g_full
            assign o_lo = w_sum[K-1:0];
        end else begin : g_part
            assign o_lo = {w_sum[K-1:0], i_mplier[N-1:K]};
        end
    endgenerate
endmodule

// File: rtl/seq_mult_rk.sv
// Iterative signed/unsigned multiplier retiring K multiplier bits per cycle,
// valid/ready on both operand and result sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | retiring K multiplier bits per cycle
// DONE  | product valid on p, held until out_ready
module seq_mult_rk
    import mult_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_mult_rk_if.slave  bus
);
    localparam int STEPS = steps(N, K);
    localparam int CW    = cnt_w(N, K);

    generate
        if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_bad_param
            $fatal(1, "seq_mult_rk: illegal parameters N=%0d K=%0d", N, K);
        end
    endgenerate

    mult_state_t    r_state;
    logic [N-1:0]   r_mcand;
    logic [N-1:0]   r_mplier;
    logic [N-1:0]   r_hi;
    logic           r_neg;
    logic [CW-1:0]  r_cnt;
    logic           r_out_valid;
    logic [2*N-1:0] r_p;

    logic [N-1:0]   w_hi_nxt;
    logic [N-1:0]   w_lo_nxt;
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_a_mag;
    logic [N-1:0]   w_b_mag;
    logic           w_in_ready;
    logic           w_accept;

    // Magnitude of -2^(N-1) wraps to 2^(N-1), which is still correct as unsigned.
    assign w_a_mag = (bus.is_signed && bus.a[N-1]) ? -bus.a : bus.a;
    assign w_b_mag = (bus.is_signed && bus.b[N-1]) ? -bus.b : bus.b;

    assign w_in_ready = rst_n && ((r_state == IDLE) || ((r_state == DONE) && bus.out_ready));
    assign w_accept   = bus.in_valid && w_in_ready;

    mult_step #(.N(N), .K(K)) u_step (
        .i_hi     (r_hi),
        .i_mplier (r_mplier),
        .i_mcand  (r_mcand),
        .o_hi     (w_hi_nxt),
        .o_lo     (w_lo_nxt)
    );

    assign w_prod = {w_hi_nxt, w_lo_nxt};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_hi        <= '0;
            r_neg       <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_p         <= '0;
        end else begin
            case (r_state)
                IDLE: ;
                RUN: begin
                    r_hi     <= w_hi_nxt;
                    r_mplier <= w_lo_nxt;
                    if (r_cnt == '0) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_p         <= r_neg ? -w_prod : w_prod;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Accept overrides the DONE->IDLE retire so back-to-back goes straight to RUN.
            if (w_accept) begin
                r_state  <= RUN;
                r_mcand  <= w_a_mag;
                r_mplier <= w_b_mag;
                r_hi     <= '0;
                r_neg    <= bus.is_signed & (bus.a[N-1] ^ bus.b[N-1]);
                r_cnt    <= CW'(STEPS - 1);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.p         = r_p;
endmodule
